// File: rtl/col_packet_arbiter.sv
// Column packet arbiter: per-column FIFOs absorb single-cycle packet pulses and a
// round-robin scheduler drains them onto one registered valid/ready output link.
module col_packet_arbiter #(
    parameter int N_COL      = 4,
    parameter int COL_W      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [16*N_COL-1:0]    pkt_data,
    input  logic [N_COL-1:0]       pkt_valid,
    output logic [COL_W+15:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic [N_COL-1:0]       ovf_flags,
    input  logic                   ovf_clr,
    output logic [7:0]             drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_flush_done_nxt;

    logic [15:0]        r_mem   [N_COL][FIFO_DEPTH];
    logic [AW-1:0]      r_wptr  [N_COL];
    logic [AW-1:0]      r_rptr  [N_COL];
    logic [CW-1:0]      r_count [N_COL];

    logic [COL_W+15:0]  r_out_data;
    logic               r_out_valid;
    logic               r_flush_done;
    logic [N_COL-1:0]   r_ovf_flags;
    logic [7:0]         r_drop_cnt;
    logic [COL_W-1:0]   r_rr;

    logic [N_COL-1:0]   w_nonempty;
    logic [N_COL-1:0]   w_pop;
    logic [N_COL-1:0]   w_push;
    logic [N_COL-1:0]   w_drop;
    logic               w_any;
    logic               w_ld;
    logic [COL_W-1:0]   w_grant;
    logic [15:0]        w_head;
    logic [8:0]         w_drop_sum;
    logic [8:0]         w_drop_total;
    logic [7:0]         w_drop_nxt;

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign flush_done = r_flush_done;
    assign ovf_flags  = r_ovf_flags;
    assign drop_cnt   = r_drop_cnt;

    assign w_ld  = !r_out_valid || out_ready;
    assign w_any = |w_nonempty;

    // Round-robin grant: nearest non-empty column after r_rr wins
    always_comb begin
        int w_idx;
        w_grant = r_rr;
        for (int i = 0; i < N_COL; i++) begin
            w_nonempty[i] = (r_count[i] != CW'(0));
        end
        // Scan from the farthest offset down so the closest candidate is assigned last
        for (int k = N_COL; k >= 1; k--) begin
            w_idx   = (int'(r_rr) + k) % N_COL;
            w_grant = w_nonempty[w_idx] ? COL_W'(w_idx) : w_grant;
        end
    end

    assign w_head = r_mem[w_grant][r_rptr[w_grant]];

    // Per-column pop/push/drop decisions and the saturating drop total
    always_comb begin
        w_pop      = '0;
        w_push     = '0;
        w_drop     = '0;
        w_drop_sum = 9'd0;
        for (int i = 0; i < N_COL; i++) begin
            w_pop[i]  = w_ld && w_any && (w_grant == COL_W'(i));
            // Pulses arriving while flushing are discarded silently, never counted as drops
            w_push[i] = pkt_valid[i] && (r_state == ST_RUN) &&
                        ((r_count[i] != CW'(FIFO_DEPTH)) || w_pop[i]);
            w_drop[i] = pkt_valid[i] && (r_state == ST_RUN) && !w_push[i];
            w_drop_sum = w_drop_sum + 9'(w_drop[i]);
        end
        w_drop_total = {1'b0, r_drop_cnt} + w_drop_sum;
        w_drop_nxt   = (w_drop_total > 9'd255) ? 8'd255 : w_drop_total[7:0];
    end

    // FIFO storage write port (contents are don't-care until counted valid)
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_COL; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wptr[i]] <= pkt_data[16*i +: 16];
            end
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_COL; i++) begin
                r_wptr[i]  <= AW'(0);
                r_rptr[i]  <= AW'(0);
                r_count[i] <= CW'(0);
            end
        end else begin
            for (int i = 0; i < N_COL; i++) begin
                if (w_push[i]) begin
                    r_wptr[i] <= r_wptr[i] + AW'(1);
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + AW'(1);
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + CW'(1);
                    2'b01:   r_count[i] <= r_count[i] - CW'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // Output register and round-robin pointer; both hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_rr        <= COL_W'(N_COL - 1);
        end else if (w_ld) begin
            if (w_any) begin
                r_out_data  <= {w_grant, w_head};
                r_out_valid <= 1'b1;
                r_rr        <= w_grant;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Overflow flags and drop counter; clear wins over a same-cycle overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_flags <= '0;
            r_drop_cnt  <= 8'd0;
        end else if (ovf_clr) begin
            r_ovf_flags <= '0;
            r_drop_cnt  <= 8'd0;
        end else begin
            r_ovf_flags <= r_ovf_flags | w_drop;
            r_drop_cnt  <= w_drop_nxt;
        end
    end

    // Flush state register and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_done <= w_flush_done_nxt;
        end
    end

    // Flush completes once FIFOs are empty and the output word is gone or leaving
    always_comb begin
        w_state_nxt      = r_state;
        w_flush_done_nxt = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_state_nxt = flush_req ? ST_FLUSH : ST_RUN;
            end
            ST_FLUSH: begin
                if (!w_any && w_ld) begin
                    w_state_nxt      = ST_RUN;
                    w_flush_done_nxt = 1'b1;
                end else begin
                    w_state_nxt      = ST_FLUSH;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

endmodule
